// File: rtl/alu_op_encoder_pkg.sv
// Shared ALU opcode and request-select definitions.
// The encoder and the opcode decoder both import this package, so the two sides cannot drift apart.
package alu_op_encoder_pkg;

    localparam int OPW_DEFAULT = 5;
    localparam int SHW_DEFAULT = 5;
    localparam int NUM_SEL     = 6;

    localparam logic [4:0] ALU_OP_ADD = 5'b00000;
    localparam logic [4:0] ALU_OP_SUB = 5'b00001;
    localparam logic [4:0] ALU_OP_AND = 5'b00010;
    localparam logic [4:0] ALU_OP_OR  = 5'b00011;
    localparam logic [4:0] ALU_OP_SLL = 5'b00100;
    localparam logic [4:0] ALU_OP_SRA = 5'b00101;

    localparam int SEL_ADD = 0;
    localparam int SEL_SUB = 1;
    localparam int SEL_AND = 2;
    localparam int SEL_OR  = 3;
    localparam int SEL_SLL = 4;
    localparam int SEL_SRA = 5;

endpackage

// File: rtl/alu_op_encoder_onehot_to_alu_op.sv
// Combinational mapping from a one-hot operation select to the ALU opcode.
// It also flags shift operations and reports whether the select is legal.
module onehot_to_alu_op
    import alu_op_encoder_pkg::*;
(
    input  logic [NUM_SEL-1:0] sel,
    output logic [4:0]         op,
    output logic               is_shift,
    output logic               onehot_ok
);

    always_comb begin
        onehot_ok = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
        op        = ALU_OP_ADD;
        if (sel[SEL_SUB]) op = ALU_OP_SUB;
        if (sel[SEL_AND]) op = ALU_OP_AND;
        if (sel[SEL_OR])  op = ALU_OP_OR;
        if (sel[SEL_SLL]) op = ALU_OP_SLL;
        if (sel[SEL_SRA]) op = ALU_OP_SRA;
        is_shift  = onehot_ok && (sel[SEL_SLL] || sel[SEL_SRA]);
    end

endmodule

// File: rtl/alu_op_encoder.sv
// Encodes one-hot ALU requests into opcodes and buffers them in a small FIFO.
// A valid/ready handshake feeds the ALU side; illegal selects are consumed and flagged.
module alu_op_encoder
    import alu_op_encoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OPW   = OPW_DEFAULT,
    parameter int SHW   = SHW_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_SEL-1:0]         in_sel,
    input  logic [SHW-1:0]             in_shamt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPW-1:0]             out_op,
    output logic [SHW-1:0]             out_shamt,
    output logic                       err_onehot,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(DEPTH - 1);

    logic [4:0]     enc_op;
    logic           enc_is_shift;
    logic           enc_ok;

    logic [CNTW-1:0] count_reg;
    logic [PTRW-1:0] wptr_reg;
    logic [PTRW-1:0] rptr_reg;
    logic            err_reg;

    logic [OPW-1:0] op_mem    [DEPTH];
    logic [SHW-1:0] shamt_mem [DEPTH];

    logic push_any;
    logic push_wr;
    logic pop;

    onehot_to_alu_op u_enc (
        .sel       (in_sel),
        .op        (enc_op),
        .is_shift  (enc_is_shift),
        .onehot_ok (enc_ok)
    );

    // in_ready comes from occupancy alone, keeping out_ready off the input path.
    assign in_ready  = (count_reg < CNTW'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push_any  = in_valid && in_ready;
    assign push_wr   = push_any && enc_ok;
    assign pop       = out_valid && out_ready;

    // Gate the head with out_valid so an empty FIFO shows zeros rather than stale data.
    assign out_op     = out_valid ? op_mem[rptr_reg]    : '0;
    assign out_shamt  = out_valid ? shamt_mem[rptr_reg] : '0;
    assign err_onehot = err_reg;
    assign count      = count_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clock) begin
                if (!reset && push_wr && (wptr_reg == PTRW'(gi))) begin
                    op_mem[gi]    <= OPW'(enc_op);
                    shamt_mem[gi] <= enc_is_shift ? in_shamt : '0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= push_any && !enc_ok;
            if (push_wr) begin
                wptr_reg <= (wptr_reg == PTR_LAST) ? '0 : wptr_reg + 1'b1;
            end
            if (pop) begin
                rptr_reg <= (rptr_reg == PTR_LAST) ? '0 : rptr_reg + 1'b1;
            end
            if (push_wr && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push_wr) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule
